serial_adder: RTL



---
 rtl/adder_pkg.sv | 18 +
 rtl/digit_adder.sv | 35 +++
 rtl/serial_adder.sv | 128 ++++++++++++
 3 files changed

// File: rtl/adder_pkg.sv
// adder_pkg: types and helpers shared by the serial adder and its digit cell.
//   state_e   - serial_adder control state (2-bit encoding)
//   cnt_width - digit counter width: clog2(n), never less than 1 bit
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = (n <= 1) ? 1 : unsigned'($clog2(n));
    return w;
  endfunction

endpackage

// File: rtl/digit_adder.sv
// digit_adder: combinational DIGIT-bit ripple chain of full-adder cells.
// Ports:
//   a, b   in  DIGIT  addend digits
//   ci     in  1      carry into bit 0
//   s      out DIGIT  digit sum
//   co     out 1      carry out of the top bit
//   c_top  out 1      carry into the top bit (feeds signed overflow)
module digit_adder #(
  parameter int unsigned DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             c_top
);

  // Carry is carried along as a single variable so the chain stays one
  // sequential evaluation rather than a self-referencing vector.
  logic c;

  always_comb begin
    c     = ci;
    c_top = 1'b0;
    s     = '0;
    for (int unsigned i = 0; i < DIGIT; i++) begin
      if (i == DIGIT - 1) c_top = c;
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    co = c;
  end

endmodule

// File: rtl/serial_adder.sv
// serial_adder: multi-cycle WIDTH-bit adder processing DIGIT bits per clock.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   in_valid/in_ready    operand handshake (a, b, cin)
//   a, b, cin            operands and carry-in
//   out_valid/out_ready  result handshake
//   sum, cout, overflow  a+b+cin mod 2^WIDTH, unsigned carry, signed overflow
// Operands accepted at edge t produce out_valid after edge t+WIDTH/DIGIT;
// results are held in DONE until out_ready.
module serial_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int unsigned NDIG = WIDTH / DIGIT;
  localparam int unsigned CW   = cnt_width(NDIG);

  if (WIDTH < 2 || DIGIT == 0 || (WIDTH % DIGIT) != 0) begin : g_param_check
    $error("serial_adder: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [DIGIT-1:0] dig_s;
  logic             dig_co;
  logic             dig_ctop;

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .a     (a_sh_q[DIGIT-1:0]),
    .b     (b_sh_q[DIGIT-1:0]),
    .ci    (carry_q),
    .s     (dig_s),
    .co    (dig_co),
    .c_top (dig_ctop)
  );

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sh_d  = a_sh_q >> DIGIT;
        b_sh_d  = b_sh_q >> DIGIT;
        // New digit enters at the top; after NDIG steps the low digit
        // computed first has reached bit 0. Written with shifts so the
        // DIGIT == WIDTH case needs no empty slice.
        sum_d   = (sum_q >> DIGIT) | (WIDTH'(dig_s) << (WIDTH - DIGIT));
        carry_d = dig_co;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(NDIG - 1)) begin
          cout_d  = dig_co;
          ovf_d   = dig_ctop ^ dig_co;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;

endmodule
